// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage that sits after the ALU. It takes the ALU result as
//   the effective byte address and rs2 as store data. It issues one req/gnt
//   transaction to data memory with byte-lane enables and lane-replicated
//   store data. For loads it aligns the returned word and sign- or
//   zero-extends it. It reports completion with a one-cycle done pulse.
//
//   Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned
//   halfword/word accesses into errors. When it is not defined, the low
//   address bits below the access size are ignored.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   memReq          start an access (sampled only while idle)
//   memWrite        1 = store, 0 = load
//   funct3          RV32I load/store size/sign encoding
//   aluResult       effective byte address
//   writeData       store data (rs2)
//   busy            access in progress
//   done            one-cycle completion pulse
//   readData        extended load result, held until the next load completes
//   lsuErr          valid with done: illegal funct3 or misaligned access
//   dmemReq/We      memory request / write enable
//   dmemAddr        word-aligned address
//   dmemByteEn      byte-lane enables
//   dmemWData       lane-replicated store data
//   dmemGnt         memory accepts the request this cycle
//   dmemRValid      load data valid
//   dmemRData       load data word
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memReq,
    input  logic                  memWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] aluResult,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  lsuErr,
    output logic                  dmemReq,
    output logic                  dmemWe,
    output logic [DATA_WIDTH-1:0] dmemAddr,
    output logic [3:0]            dmemByteEn,
    output logic [DATA_WIDTH-1:0] dmemWData,
    input  logic                  dmemGnt,
    input  logic                  dmemRValid,
    input  logic [DATA_WIDTH-1:0] dmemRData
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e          state_q;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offs_q;

    logic                  req_legal;
    logic                  req_aligned;
    logic [3:0]            be_new;
    logic [DATA_WIDTH-1:0] wdata_new;
    logic [DATA_WIDTH-1:0] byte_sel;
    logic [DATA_WIDTH-1:0] half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    // Decode the incoming request: legality, alignment, lanes and store data.
    always_comb begin
        req_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~memWrite;
            default:                req_legal = 1'b0;
        endcase

        req_aligned = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'b01:   req_aligned = ~aluResult[0];
            2'b10:   req_aligned = (aluResult[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase
`endif

        be_new    = 4'b1111;
        wdata_new = writeData;
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << aluResult[1:0];
                wdata_new = {4{writeData[7:0]}};
            end
            2'b01: begin
                // Halfword lane comes from a[1] only; a[0] is ignored here.
                be_new    = 4'b0011 << {aluResult[1], 1'b0};
                wdata_new = {2{writeData[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = writeData;
            end
        endcase
    end

    // Align and extend the returned load word using the captured offset.
    always_comb begin
        byte_sel = dmemRData >> {offs_q, 3'b000};
        half_sel = dmemRData >> {offs_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel[15:0]};
            default: load_ext = dmemRData;
        endcase
    end

    // Single-process FSM; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            funct3_q   <= 3'b000;
            offs_q     <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            lsuErr     <= 1'b0;
            readData   <= '0;
            dmemReq    <= 1'b0;
            dmemWe     <= 1'b0;
            dmemAddr   <= '0;
            dmemByteEn <= 4'b0000;
            dmemWData  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memReq) begin
                        write_q  <= memWrite;
                        funct3_q <= funct3;
                        offs_q   <= aluResult[1:0];
                        busy     <= 1'b1;
                        if (req_legal && req_aligned) begin
                            state_q    <= StReq;
                            dmemReq    <= 1'b1;
                            dmemWe     <= memWrite;
                            dmemAddr   <= {aluResult[DATA_WIDTH-1:2], 2'b00};
                            dmemByteEn <= be_new;
                            dmemWData  <= wdata_new;
                        end else begin
                            // Rejected access: no memory traffic, report at once.
                            state_q <= StDone;
                            done    <= 1'b1;
                            lsuErr  <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (dmemGnt) begin
                        dmemReq    <= 1'b0;
                        dmemWe     <= 1'b0;
                        dmemByteEn <= 4'b0000;
                        if (write_q) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (dmemRValid) begin
                        readData <= load_ext;
                        state_q  <= StDone;
                        done     <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    lsuErr  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. A transaction-level model computes the
//   lanes, the store data, the load extension and the cycle of each event from
//   the access rules. A negedge compare process checks the DUT against that
//   model on every cycle. Literal checks pin the model on hand-worked cases.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memReq = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] aluResult = 32'h0;
    logic [31:0] writeData = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] readData;
    logic        lsuErr;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemByteEn;
    logic [31:0] dmemWData;
    logic        dmemGnt = 1'b0;
    logic        dmemRValid = 1'b0;
    logic [31:0] dmemRData = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .memReq     (memReq),
        .memWrite   (memWrite),
        .funct3     (funct3),
        .aluResult  (aluResult),
        .writeData  (writeData),
        .busy       (busy),
        .done       (done),
        .readData   (readData),
        .lsuErr     (lsuErr),
        .dmemReq    (dmemReq),
        .dmemWe     (dmemWe),
        .dmemAddr   (dmemAddr),
        .dmemByteEn (dmemByteEn),
        .dmemWData  (dmemWData),
        .dmemGnt    (dmemGnt),
        .dmemRValid (dmemRValid),
        .dmemRData  (dmemRData)
    );

    int total = 0;
    int bad   = 0;

    // Model expectations for the current cycle.
    bit          chk_en    = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_req   = 1'b0;
    logic        exp_err   = 1'b0;
    logic        exp_we    = 1'b0;
    logic [31:0] exp_addr  = 32'h0;
    logic [3:0]  exp_be    = 4'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [31:0] exp_rd    = 32'h0;

    // Snapshots of the last transaction, for literal checks.
    logic        req_seen;
    logic [31:0] snap_addr;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;
    logic        snap_we;
    logic        snap_err;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_legal(input bit we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // First byte lane of the access, after dropping address bits below the size.
    function automatic int m_base(input logic [2:0] f3, input logic [31:0] a);
        int s = m_size(f3);
        return (int'(a % 4) / s) * s;
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) == 0;
`else
        return (f3 == f3) && (a == a);
`endif
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] r;
        int s = m_size(f3);
        int b = m_base(f3, a);
        for (int i = 0; i < 4; i++) r[i] = (i >= b) && (i < b + s);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int s = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int s = m_size(f3);
        longint v = longint'(rd >> (8 * m_base(f3, a)));
        longint span;
        if (s < 4) begin
            span = longint'(1) << (8 * s);
            v = v % span;
            if (!f3[2] && (v >= span / 2)) v = v - span;
        end
        return v[31:0];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", 32'(busy), 32'(exp_busy));
            cmp("done", 32'(done), 32'(exp_done));
            cmp("dmemReq", 32'(dmemReq), 32'(exp_req));
            cmp("readData", readData, exp_rd);
            cmp("lsuErr", 32'(lsuErr), 32'(exp_done & exp_err));
            if (exp_req) begin
                cmp("dmemAddr", dmemAddr, exp_addr);
                cmp("dmemByteEn", 32'(dmemByteEn), 32'(exp_be));
                cmp("dmemWe", 32'(dmemWe), 32'(exp_we));
                if (exp_we) cmp("dmemWData", dmemWData, exp_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    // gw: cycles gnt is held low in REQ; rw: cycles between gnt and rvalid.
    // noise: toggle memReq and scramble inputs while busy.
    // rst_at: cycle index (1 = first cycle after acceptance) to pulse rst, 0 = none.
    task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int gw,
                       input int rw, input bit noise, input int rst_at);
        bit txn  = m_legal(we, f3) && m_aligned(f3, a);
        int lat  = !txn ? 1 : (we ? gw + 2 : gw + rw + 3);
        int last = (rst_at > 0) ? gw + rw + 5 : lat + 1;
        int dones = 0;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = m_be(f3, a);
        exp_wdata = m_wdata(f3, wd);
        exp_we    = we;
        req_seen  = 1'b0;
        snap_err  = 1'b0;
        @(posedge clk); #1;
        memReq    = 1'b1;
        memWrite  = we;
        funct3    = f3;
        aluResult = a;
        writeData = wd;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            memReq = noise && (n < lat) && n[0];
            if (noise) begin
                memWrite  = ~we;
                funct3    = 3'($urandom);
                aluResult = $urandom;
                writeData = $urandom;
            end
            rst        = (rst_at == n);
            dmemGnt    = (n == gw + 1);
            dmemRValid = (n == gw + 2 + rw);
            dmemRData  = dmemRValid ? rd : ~rd;
            if (rst_at > 0 && n > rst_at) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_req  = 1'b0;
                exp_err  = 1'b0;
                exp_rd   = 32'h0;
            end else begin
                exp_busy = (n <= lat);
                exp_done = (n == lat);
                exp_req  = txn && (n <= gw + 1);
                exp_err  = !txn;
                if (n == lat && txn && !we) exp_rd = m_load(f3, a, rd);
            end
            if (dmemReq && !req_seen) begin
                req_seen   = 1'b1;
                snap_addr  = dmemAddr;
                snap_be    = dmemByteEn;
                snap_wdata = dmemWData;
                snap_we    = dmemWe;
            end
            if (done) begin
                dones++;
                snap_err = lsuErr;
            end
        end
        memReq     = 1'b0;
        rst        = 1'b0;
        dmemGnt    = 1'b0;
        dmemRValid = 1'b0;
        if (rst_at == 0) cmp("done_count", 32'(dones), 32'd1);
        else cmp("done_after_rst", 32'(dones), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cmp("rst_dmemAddr", dmemAddr, 32'h0);
        cmp("rst_dmemByteEn", 32'(dmemByteEn), 32'h0);
        cmp("rst_dmemWData", dmemWData, 32'h0);
        cmp("rst_dmemWe", 32'(dmemWe), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SW with immediate grant.
        run(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 0);
        cmp("t1_addr", snap_addr, 32'h100);
        cmp("t1_be", 32'(snap_be), 32'hF);
        cmp("t1_we", 32'(snap_we), 32'h1);
        cmp("t1_wdata", snap_wdata, 32'hDEADBEEF);

        // LB / LBU extension.
        run(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0);
        cmp("t2_lb", readData, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 0);
        cmp("t2_lbu", readData, 32'h00000080);

        // LH / LHU on the upper half, delayed grant and data.
        run(1'b0, 3'b001, 32'h206, 32'h0, 32'h80017FFF, 1, 2, 1'b0, 0);
        cmp("lh_upper", readData, 32'hFFFF8001);
        run(1'b0, 3'b101, 32'h206, 32'h0, 32'h80017FFF, 0, 1, 1'b0, 0);
        cmp("lhu_upper", readData, 32'h00008001);

        // Store lane steering.
        run(1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 0, 0, 1'b0, 0);
        cmp("t3_be", 32'(snap_be), 32'hC);
        cmp("t3_wdata", snap_wdata, 32'hABCDABCD);
        run(1'b1, 3'b000, 32'h701, 32'h1234565A, 32'h0, 1, 0, 1'b0, 0);
        cmp("sb_be", 32'(snap_be), 32'h2);
        cmp("sb_wdata", snap_wdata, 32'h5A5A5A5A);

        // Stalled grant with memReq noise while busy.
        run(1'b1, 3'b010, 32'h500, 32'h12345678, 32'h0, 3, 0, 1'b1, 0);
        run(1'b0, 3'b010, 32'h604, 32'h0, 32'hCAFEF00D, 2, 1, 1'b1, 0);
        cmp("lw_stall", readData, 32'hCAFEF00D);

        // Illegal store leaves readData alone.
        run(1'b1, 3'b100, 32'h608, 32'h0, 32'h0, 0, 0, 1'b0, 0);
        cmp("ill_st_err", 32'(snap_err), 32'h1);
        cmp("ill_st_noreq", 32'(req_seen), 32'h0);
        cmp("ill_st_rd", readData, 32'hCAFEF00D);

        // Reset while waiting for load data; the late rvalid must be ignored.
        run(1'b0, 3'b010, 32'h60C, 32'h0, 32'h11111111, 0, 4, 1'b0, 3);
        cmp("t5_readData", readData, 32'h0);
        cmp("t5_busy", 32'(busy), 32'h0);
        run(1'b0, 3'b010, 32'h610, 32'h0, 32'h24681357, 0, 0, 1'b0, 0);
        cmp("post_rst_lw", readData, 32'h24681357);

        // Misaligned word load and halfword load.
        run(1'b0, 3'b010, 32'h401, 32'h0, 32'h55AA55AA, 0, 0, 1'b0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        cmp("t6_noreq", 32'(req_seen), 32'h0);
        cmp("t6_err", 32'(snap_err), 32'h1);
        cmp("t6_rd", readData, 32'h24681357);
`else
        cmp("t6_addr", snap_addr, 32'h400);
        cmp("t6_be", 32'(snap_be), 32'hF);
        cmp("t6_err", 32'(snap_err), 32'h0);
        cmp("t6_rd", readData, 32'h55AA55AA);
`endif
        run(1'b0, 3'b001, 32'h203, 32'h0, 32'hF00D8765, 0, 0, 1'b0, 0);

        // Illegal load funct3.
        run(1'b0, 3'b011, 32'h700, 32'h0, 32'h0, 0, 0, 1'b0, 0);
        cmp("ill_ld_err", 32'(snap_err), 32'h1);
        cmp("ill_ld_noreq", 32'(req_seen), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
